// File: rtl/fbcpu_pkg.sv
// Shared definitions for the FBCPU run/boot controller: default widths,
// instruction opcodes and the controller state encoding.
package fbcpu_pkg;

    localparam int DEF_ADDRESS_WIDTH = 6;
    localparam int DEF_DATA_WIDTH    = 10;
    localparam int DEF_CYC_W         = 16;
    localparam int DEF_MAX_RUN       = 1000;
    localparam int DEF_HALT_DETECT   = 8;
    localparam int PC_W              = 6;
    localparam int OPC_W             = 4;

    // Instruction word: opcode in the top OPC_W bits, operand address below.
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd3;
    localparam logic [OPC_W-1:0] OP_MUL   = 4'd4;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'd6;
    localparam logic [OPC_W-1:0] OP_JZ    = 4'd7;
    localparam logic [OPC_W-1:0] OP_NOP   = 4'd8;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_OUT
    } ctrl_state_t;

endpackage

// File: rtl/fbcpu_halt_detect.sv
// Declares the CPU halted once its PC has stayed unchanged for HALT_DETECT
// consecutive enabled cycles; i_start clears the PC shadow and the count.
module fbcpu_halt_detect import fbcpu_pkg::*; #(
    parameter int HALT_DETECT = DEF_HALT_DETECT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_en,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_halted
);

    localparam int CNT_W = $clog2(HALT_DETECT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALT_DETECT);

    logic [PC_W-1:0]  r_pc_q;
    logic [CNT_W-1:0] r_stable_cnt;
    logic [CNT_W-1:0] w_stable_next;

    always_comb begin
        w_stable_next = '0;
        if (i_pc == r_pc_q) begin
            w_stable_next = (r_stable_cnt == CNT_MAX) ? r_stable_cnt : r_stable_cnt + 1'b1;
        end
        o_halted = i_en && (w_stable_next == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_pc_q       <= '0;
            r_stable_cnt <= '0;
        end else if (i_en) begin
            r_pc_q       <= i_pc;
            r_stable_cnt <= w_stable_next;
        end
    end

endmodule

// File: rtl/fbcpu_run_ctrl.sv
// Run/boot controller: owns the shared program RAM, streams programs in and
// RAM windows out for the host, and supervises CPU runs (halt/timeout/abort).
module fbcpu_run_ctrl import fbcpu_pkg::*; #(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CYC_W         = DEF_CYC_W,
    parameter int MAX_RUN       = DEF_MAX_RUN,
    parameter int HALT_DETECT   = DEF_HALT_DETECT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_load,
    input  logic                     cmd_run,
    input  logic                     cmd_dump,
    input  logic                     cmd_abort,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [ADDRESS_WIDTH:0]   cmd_len,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_ready,
    output logic                     dp_valid,
    output logic [DATA_WIDTH-1:0]    dp_data,
    input  logic                     dp_ready,
    output logic                     busy,
    output logic                     done_halt,
    output logic                     done_timeout,
    output logic [CYC_W-1:0]         run_cycles,
    output logic                     cpu_rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
    input  logic [DATA_WIDTH-1:0]    cpu_mdrin,
    input  logic                     cpu_ramwr,
    input  logic [PC_W-1:0]          cpu_pc,
    output logic [DATA_WIDTH-1:0]    cpu_mdrout,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    localparam logic [ADDRESS_WIDTH:0] LEN_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [CYC_W-1:0]       RUN_MAX = CYC_W'(MAX_RUN);

    ctrl_state_t              r_state;
    ctrl_state_t              w_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH:0]   r_remain;
    logic                     r_dp_valid;
    logic [DATA_WIDTH-1:0]    r_dp_data;
    logic                     r_done_halt;
    logic                     r_done_timeout;
    logic [CYC_W-1:0]         r_run_cycles;

    logic                     w_len_ok;
    logic                     w_last;
    logic [CYC_W-1:0]         w_cyc_next;
    logic                     w_timeout;
    logic                     w_halted;
    logic                     w_in_run;
    logic                     w_load_start;
    logic                     w_run_start;
    logic                     w_dump_start;
    logic                     w_ld_accept;
    logic                     w_dp_accept;

    assign w_len_ok   = (cmd_len != '0) && (cmd_len <= LEN_MAX);
    assign w_last     = (r_remain == {{ADDRESS_WIDTH{1'b0}}, 1'b1});
    assign w_cyc_next = r_run_cycles + 1'b1;
    assign w_timeout  = (w_cyc_next == RUN_MAX);
    assign w_in_run   = (r_state == ST_RUN);

    assign busy         = (r_state != ST_IDLE);
    assign dp_valid     = r_dp_valid;
    assign dp_data      = r_dp_data;
    assign done_halt    = r_done_halt;
    assign done_timeout = r_done_timeout;
    assign run_cycles   = r_run_cycles;

    fbcpu_halt_detect #(
        .HALT_DETECT(HALT_DETECT)
    ) u_halt_detect (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_run_start),
        .i_en     (w_in_run),
        .i_pc     (cpu_pc),
        .o_halted (w_halted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load_start = 1'b0;
        w_run_start  = 1'b0;
        w_dump_start = 1'b0;
        w_ld_accept  = 1'b0;
        w_dp_accept  = 1'b0;
        ld_ready     = 1'b0;
        cpu_rst      = 1'b1;
        ram_addr     = r_addr;
        ram_wdata    = '0;
        ram_we       = 1'b0;
        cpu_mdrout   = '0;

        case (r_state)
            ST_IDLE: begin
                // The highest-priority asserted command wins even when its
                // length is invalid; it is then dropped rather than deferring.
                if (cmd_load) begin
                    if (w_len_ok) begin
                        w_load_start = 1'b1;
                        w_next       = ST_LOAD;
                    end
                end else if (cmd_run) begin
                    w_run_start = 1'b1;
                    w_next      = ST_RUN;
                end else if (cmd_dump) begin
                    if (w_len_ok) begin
                        w_dump_start = 1'b1;
                        w_next       = ST_DUMP_RD;
                    end
                end
            end
            ST_LOAD: begin
                ld_ready  = 1'b1;
                ram_wdata = ld_data;
                if (ld_valid) begin
                    ram_we      = 1'b1;
                    w_ld_accept = 1'b1;
                    if (w_last) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                cpu_rst    = 1'b0;
                ram_addr   = cpu_mar;
                ram_wdata  = cpu_mdrin;
                ram_we     = cpu_ramwr;
                cpu_mdrout = ram_rdata;
                if (w_halted || w_timeout || cmd_abort) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DUMP_RD: begin
                w_next = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                w_next = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (dp_ready) begin
                    w_dp_accept = 1'b1;
                    w_next      = w_last ? ST_IDLE : ST_DUMP_RD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= '0;
            r_remain       <= '0;
            r_dp_valid     <= 1'b0;
            r_dp_data      <= '0;
            r_done_halt    <= 1'b0;
            r_done_timeout <= 1'b0;
            r_run_cycles   <= '0;
        end else begin
            if (w_load_start || w_dump_start) begin
                r_addr   <= cmd_addr;
                r_remain <= cmd_len;
            end
            if (w_ld_accept || w_dp_accept) begin
                r_addr   <= r_addr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end
            if (r_state == ST_DUMP_WAIT) begin
                r_dp_data  <= ram_rdata;
                r_dp_valid <= 1'b1;
            end
            if (w_dp_accept) begin
                r_dp_valid <= 1'b0;
            end
            if (w_run_start) begin
                r_run_cycles   <= '0;
                r_done_halt    <= 1'b0;
                r_done_timeout <= 1'b0;
            end
            if (w_in_run) begin
                r_run_cycles <= w_cyc_next;
                if (w_halted) begin
                    r_done_halt <= 1'b1;
                end else if (w_timeout) begin
                    r_done_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fbcpu_run_ctrl.sv
// Bench for fbcpu_run_ctrl: a small accumulator CPU and a synchronous RAM
// surround the controller; a monitor scores dump words and run results.
module tb_fbcpu_run_ctrl;
    import fbcpu_pkg::*;

    localparam int AW = 6;
    localparam int DW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_load = 1'b0, cmd_run = 1'b0, cmd_dump = 1'b0, cmd_abort = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          dp_valid;
    logic [DW-1:0] dp_data;
    logic          dp_ready = 1'b0;
    logic          busy, done_halt, done_timeout;
    logic [CW-1:0] run_cycles;
    logic          cpu_rst;
    logic [AW-1:0] cpu_mar;
    logic [DW-1:0] cpu_mdrin;
    logic          cpu_ramwr;
    logic [5:0]    cpu_pc;
    logic [DW-1:0] cpu_mdrout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    fbcpu_run_ctrl #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CYC_W(CW), .MAX_RUN(1000), .HALT_DETECT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_dump(cmd_dump), .cmd_abort(cmd_abort),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .dp_valid(dp_valid), .dp_data(dp_data), .dp_ready(dp_ready),
        .busy(busy), .done_halt(done_halt), .done_timeout(done_timeout), .run_cycles(run_cycles),
        .cpu_rst(cpu_rst), .cpu_mar(cpu_mar), .cpu_mdrin(cpu_mdrin), .cpu_ramwr(cpu_ramwr),
        .cpu_pc(cpu_pc), .cpu_mdrout(cpu_mdrout),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Accumulator CPU: fetch (2 cycles), execute, optional memory-read cycle.
    typedef enum logic [1:0] {C_F0, C_F1, C_EX, C_M1} cpu_st_t;
    cpu_st_t       cs;
    logic [5:0]    pc;
    logic [DW-1:0] ir, acc;

    assign cpu_pc = pc;
    always_comb begin
        cpu_mar   = (cs == C_F0) ? pc : ir[5:0];
        cpu_mdrin = acc;
        cpu_ramwr = (cs == C_EX) && (ir[9:6] == OP_STORE);
    end

    always @(posedge clk) begin
        if (cpu_rst) begin
            cs <= C_F0; pc <= '0; ir <= '0; acc <= '0;
        end else begin
            case (cs)
                C_F0: cs <= C_F1;
                C_F1: begin ir <= cpu_mdrout; pc <= pc + 6'd1; cs <= C_EX; end
                C_EX: begin
                    case (ir[9:6])
                        OP_LOAD, OP_ADD, OP_SUB, OP_MUL: cs <= C_M1;
                        OP_JMP:  begin pc <= ir[5:0]; cs <= C_F0; end
                        OP_JZ:   begin if (acc == '0) pc <= ir[5:0]; cs <= C_F0; end
                        OP_HALT: cs <= C_EX;
                        default: cs <= C_F0;
                    endcase
                end
                default: begin
                    case (ir[9:6])
                        OP_LOAD: acc <= cpu_mdrout;
                        OP_ADD:  acc <= acc + cpu_mdrout;
                        OP_SUB:  acc <= acc - cpu_mdrout;
                        default: acc <= DW'(acc * cpu_mdrout);
                    endcase
                    cs <= C_F0;
                end
            endcase
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic          halt;
        logic          tmo;
        logic [CW-1:0] cyc;
    } run_res_t;

    run_res_t      exp_run[$];
    logic [DW-1:0] exp_dump[$];

    function automatic run_res_t mk_res(input logic h, input logic t, input int c);
        run_res_t r;
        r.halt = h; r.tmo = t; r.cyc = CW'(c);
        return r;
    endfunction

    // Monitor: scores every presented dump word and every completed run.
    initial begin : monitor
        logic     prev_cpu_rst;
        run_res_t e;
        prev_cpu_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dp_valid) begin
                    if (exp_dump.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL dump_unexpected: got 0x%0h, expected no word", dp_data);
                    end else begin
                        chk("dump_data", dp_data, exp_dump[0]);
                        if (dp_ready) void'(exp_dump.pop_front());
                    end
                end
                if (cpu_rst && !prev_cpu_rst) begin
                    if (exp_run.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL run_unexpected: got run end, expected none");
                    end else begin
                        e = exp_run.pop_front();
                        chk("run_done_halt", done_halt, e.halt);
                        chk("run_done_timeout", done_timeout, e.tmo);
                        chk("run_cycles", run_cycles, e.cyc);
                    end
                end
            end
            prev_cpu_rst = cpu_rst;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

    logic [DW-1:0] wbuf [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc, input string name, output int cycles);
        cycles = 0;
        while (busy && cycles < maxc) begin
            tick();
            cycles++;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL %s_bound: got busy=1 after %0d cycles, expected 0", name, maxc);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_dp_data", dp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_halt", done_halt, 0);
        chk("rst_done_timeout", done_timeout, 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_cpu_mdrout", cpu_mdrout, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
    endtask

    task automatic do_load(input logic [AW-1:0] a, input int n);
        cmd_addr = a; cmd_len = n[AW:0]; cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 1) begin
                ld_valid = 1'b0;
                tick();
            end
            chk("load_ld_ready", ld_ready, 1);
            ld_valid = 1'b1; ld_data = wbuf[i];
            tick();
        end
        ld_valid = 1'b0;
        chk("load_end_busy", busy, 0);
        chk("load_end_ld_ready", ld_ready, 0);
    endtask

    task automatic do_run(input run_res_t e, input int maxc);
        int c;
        exp_run.push_back(e);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("run_cpu_rst", cpu_rst, 0);
        wait_idle(maxc, "run", c);
        chk("post_run_cpu_rst", cpu_rst, 1);
        chk("post_run_cpu_mdrout", cpu_mdrout, 0);
        tick();
    endtask

    task automatic do_dump(input logic [AW-1:0] a, input int n, input bit stall);
        int c;
        for (int i = 0; i < n; i++) exp_dump.push_back(wbuf[i]);
        dp_ready = !stall;
        cmd_addr = a; cmd_len = n[AW:0]; cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        if (!stall) begin
            wait_idle(4 * n + 4, "dump", c);
            chk("dump_cycles", c, 3 * n);
        end else begin
            for (int i = 0; i < n; i++) begin
                c = 0;
                while (!dp_valid && c < 10) begin
                    tick();
                    c++;
                end
                if (!dp_valid) begin
                    n_cmp++; n_err++;
                    $display("FAIL dump_valid_bound: got dp_valid=0 after 10 cycles, expected 1");
                    break;
                end
                repeat (5) tick();
                dp_ready = 1'b1;
                tick();
                dp_ready = 1'b0;
            end
            wait_idle(10, "dump_stall", c);
        end
        dp_ready = 1'b0;
        tick();
    endtask

    initial begin : stimulus
        int c;
        repeat (3) tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // Program: A = mem[10] + mem[11]; mem[12] = A; halt
        wbuf[0] = {OP_LOAD, 6'd10};
        wbuf[1] = {OP_ADD, 6'd11};
        wbuf[2] = {OP_STORE, 6'd12};
        wbuf[3] = {OP_HALT, 6'd0};
        do_load(6'd0, 4);
        wbuf[0] = 10'd5; wbuf[1] = 10'd7;
        do_load(6'd10, 2);
        do_run(mk_res(1'b1, 1'b0, 22), 200);
        wbuf[0] = 10'd12;
        do_dump(6'd12, 1, 1'b0);
        wbuf[0] = 10'd5; wbuf[1] = 10'd7;
        do_dump(6'd10, 2, 1'b0);

        // HALT at address 0
        wbuf[0] = {OP_HALT, 6'd0};
        do_load(6'd0, 1);
        do_run(mk_res(1'b1, 1'b0, 11), 200);

        // JMP 0 forever
        wbuf[0] = {OP_JMP, 6'd0};
        do_load(6'd0, 1);
        do_run(mk_res(1'b0, 1'b1, 1000), 2000);

        // Abort at run cycle 20, with a load command ignored mid-run
        exp_run.push_back(mk_res(1'b0, 1'b0, 20));
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        repeat (4) tick();
        cmd_addr = 6'd0; cmd_len = 7'd1; cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("abort_load_ignored_ld_ready", ld_ready, 0);
        chk("abort_load_ignored_cpu_rst", cpu_rst, 0);
        repeat (14) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done_halt", done_halt, 0);
        chk("abort_done_timeout", done_timeout, 0);
        chk("abort_run_cycles", run_cycles, 20);
        tick();

        // Wrapping load and stalled dump
        wbuf[0] = 10'h111; wbuf[1] = 10'h222; wbuf[2] = 10'h333;
        do_load(6'd62, 3);
        do_dump(6'd62, 3, 1'b1);

        // Reset in the middle of a load
        cmd_addr = 6'd20; cmd_len = 7'd4; cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        ld_valid = 1'b1; ld_data = 10'h0AA;
        repeat (2) tick();
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // All three commands at once: load wins
        cmd_addr = 6'd5; cmd_len = 7'd1;
        cmd_load = 1'b1; cmd_run = 1'b1; cmd_dump = 1'b1;
        tick();
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_dump = 1'b0;
        chk("prio_ld_ready", ld_ready, 1);
        chk("prio_cpu_rst", cpu_rst, 1);
        ld_valid = 1'b1; ld_data = 10'h155;
        tick();
        ld_valid = 1'b0;
        chk("prio_load_end_busy", busy, 0);
        wbuf[0] = 10'h155;
        do_dump(6'd5, 1, 1'b0);

        // Invalid lengths and abort in IDLE are ignored
        cmd_len = 7'd0; cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("len0_load_busy", busy, 0);
        cmd_len = 7'd65; cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        chk("len65_dump_busy", busy, 0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        // Full-size window: 64 words from address 33
        for (int i = 0; i < 64; i++) wbuf[i] = DW'(i * 13 + 3);
        do_load(6'd33, 64);
        do_dump(6'd33, 64, 1'b0);

        repeat (3) tick();
        chk("dump_queue_drained", exp_dump.size(), 0);
        chk("run_queue_drained", exp_run.size(), 0);
        c = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fbcpu_run_ctrl.md
Name: fbcpu_run_ctrl

Overview:
Run/boot controller that owns the single-port program/data RAM shared with the FBCPU core.
- Outside a run, it holds the CPU in reset and gives a host three operations: stream-load a program into RAM, start a run, and stream-dump a RAM window back out.
- During a run, it hands the RAM to the CPU. It ends the run on halt detection (PC stable), on cycle timeout, or on host abort.

Parameters:
ADDRESS_WIDTH, 6, RAM address width; addresses wrap modulo 2^ADDRESS_WIDTH.
DATA_WIDTH, 10, RAM/instruction word width.
CYC_W, 16, width of the run-cycle counter.
MAX_RUN, 1000, run timeout in CPU-active cycles (must be less than 2^CYC_W).
HALT_DETECT, 8, consecutive cycles with unchanged PC that count as halted (must exceed 4).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_load  in  1  pulse: start load at cmd_addr for cmd_len words
cmd_run  in  1  pulse: release CPU
cmd_dump  in  1  pulse: start dump at cmd_addr for cmd_len words
cmd_abort  in  1  pulse: end RUN immediately
cmd_addr  in  ADDRESS_WIDTH  start address for load/dump
cmd_len  in  ADDRESS_WIDTH+1  word count, 1..2^ADDRESS_WIDTH
ld_valid  in  1  load word valid
ld_data  in  DATA_WIDTH  load word
ld_ready  out  1  load word accepted when valid&ready
dp_valid  out  1  dump word valid
dp_data  out  DATA_WIDTH  dump word
dp_ready  in  1  host accepts dump word
busy  out  1  state != IDLE
done_halt  out  1  sticky: last run ended by halt detect
done_timeout  out  1  sticky: last run ended by MAX_RUN
run_cycles  out  CYC_W  cycles with cpu_rst=0 in last/current run
cpu_rst  out  1  reset to CPU core
cpu_mar  in  ADDRESS_WIDTH  CPU address
cpu_mdrin  in  DATA_WIDTH  CPU write data
cpu_ramwr  in  1  CPU write enable
cpu_pc  in  6  CPU program counter
cpu_mdrout  out  DATA_WIDTH  read data to CPU
ram_addr  out  ADDRESS_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_WIDTH  RAM read data; synchronous read, valid 1 cycle after ram_addr

Behaviour:
- Reset (any state, including mid-load, mid-run or mid-dump):
  - state=IDLE, cpu_rst=1.
  - ld_ready, dp_valid, dp_data, busy, done_halt, done_timeout, run_cycles all 0.
  - ram_we=0; ram_addr, ram_wdata and cpu_mdrout are 0.
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT.
- cpu_rst=1 in every state except RUN.
- RAM mux:
  - RUN: ram_addr=cpu_mar, ram_wdata=cpu_mdrin, ram_we=cpu_ramwr, cpu_mdrout=ram_rdata.
  - Otherwise the controller drives the RAM and cpu_mdrout=0.
- IDLE command handling:
  - Commands are sampled only in IDLE; they are ignored in every other state.
  - Priority when several are asserted together: load > run > dump.
  - cmd_len=0 or cmd_len>2^ADDRESS_WIDTH: command ignored, stay IDLE.
  - cmd_abort in IDLE: no effect.
- LOAD:
  - ld_ready=1. Each ld_valid&ld_ready writes ld_data to the address counter in the same cycle (ram_we=1); counter increments with wrap.
  - After the cmd_len-th accepted word, go to IDLE next cycle; ld_ready=0 there.
- RUN:
  - Entry clears run_cycles, done_halt, done_timeout, the PC shadow pc_q (to 0) and the stable counter.
  - Every RUN cycle: run_cycles+=1. If cpu_pc==pc_q, stable_cnt+=1, else stable_cnt=0. Then pc_q<=cpu_pc.
  - Exit conditions, evaluated every RUN cycle; exit to IDLE at the end of that cycle:
    - stable_cnt reaches HALT_DETECT in this cycle: done_halt=1.
    - run_cycles reaches MAX_RUN: done_timeout=1.
    - cmd_abort: no flag set.
  - Simultaneous exits: halt > timeout > abort.
  - run_cycles holds its final value until the next run or reset.
- DUMP:
  - DUMP_RD drives ram_addr=counter.
  - DUMP_WAIT captures ram_rdata into dp_data and sets dp_valid=1.
  - DUMP_OUT holds dp_valid and dp_data stable until dp_ready.
  - On handshake: dp_valid=0 and the counter increments (wrap). Go to IDLE if it was the last word, else back to DUMP_RD.
  - Throughput is 1 word per 3 cycles when dp_ready is held high.
- Run results are independent of leftover RAM content: the CPU always starts from PC=0.

Decomposition:
- Shared package fbcpu_pkg:
  - opcode constants: LOAD=0, STORE=1, ADD=2, SUB=3, MUL=4, JMP=6, JZ=7, NOP=8, HALT=9.
  - controller state encoding.
  - default widths.
- Sub-module fbcpu_halt_detect: contains pc_q, stable_cnt and the halted output, cleared by a start input.

Test Plan:
- Program execution: load at addr 0, len 4, words 0x00A, 0x08B, 0x04C, 0x240; load at addr 10, len 2, words 5, 7; cmd_run -> done_halt=1, done_timeout=0, cpu_rst=1 after exit. Then dump addr 12, len 1 -> dp_data=12.
- HALT-only program (0x240 at addr 0), run -> exit after exactly run_cycles=11, done_halt=1.
- Timeout: 0x180 (JMP 0) at addr 0, run -> run_cycles=1000, done_timeout=1, done_halt=0.
- Dump back-pressure: load 3 words 0x111, 0x222, 0x333 at addr 62 (wrapping to 0); dump addr 62 len 3 with dp_ready low for 5 cycles on each word -> data 0x111, 0x222, 0x333 in order, dp_data stable while stalled.
- Abort: run the JMP 0 program, cmd_abort at run cycle 20 -> IDLE next cycle, run_cycles=20, neither done flag set. Also assert cmd_load during RUN -> ignored.
- Reset mid-load: rst after 2 of 4 words -> IDLE, ld_ready=0, busy=0. A new load of len 1 completes normally afterwards.
